// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
//   DATA_W : data word width (matches the single_port_ram data ports)
//   ADDR_W : RAM address width
//   DEPTH  : RAM words, 2**ADDR_W
//   CNT_W  : width of the occupancy count, which spans 0..DEPTH+1
package ram_fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  // ST_RD_WAIT is the cycle in which the RAM returns the word read in ST_IDLE.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that sequences the single port of a sibling 64x8
// single_port_ram as a circular buffer, with a one-entry output register
// in front of the reader.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   push_valid/push_ready/push_data writer handshake
//   pop_valid/pop_ready/pop_data    reader handshake (head of FIFO)
//   count, full, empty              occupancy status
//   ram_data_in, ram_address,
//   ram_write_enable, ram_data_out  connection to the RAM port
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  fifo_state_e       state_q;
  fifo_state_e       state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  mem_count_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              rd_issue;
  logic              push_fire;
  logic              pop_fire;
  logic              mem_empty;
  logic              mem_full;

  assign mem_empty = (mem_count_q == '0);
  assign mem_full  = (mem_count_q == CNT_W'(DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and read issue: a read is launched only from registered
  // state, so pop_ready never reaches the RAM address path.
  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!out_valid_q && !mem_empty) begin
          rd_issue = 1'b1;
          state_d  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshakes: a pending read owns the RAM port, so writers stall for it.
  assign push_ready = !rd_issue && !mem_full;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = out_valid_q && pop_ready;

  // RAM port drive.
  assign ram_address      = rd_issue ? rd_ptr_q : wr_ptr_q;
  assign ram_write_enable = push_fire;
  assign ram_data_in      = push_data;

  // Pointers and RAM occupancy; a simultaneous read and write cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      if (push_fire) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      case ({push_fire, rd_issue})
        2'b10:   mem_count_q <= mem_count_q + CNT_W'(1);
        2'b01:   mem_count_q <= mem_count_q - CNT_W'(1);
        default: mem_count_q <= mem_count_q;
      endcase
    end
  end

  // Output register. A read is only issued while it is empty, so capture
  // and pop can never coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (state_q == ST_RD_WAIT) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ram_data_out;
    end else if (pop_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  assign pop_valid = out_valid_q;
  assign pop_data  = out_data_q;

  // Words held: RAM region + word in flight from RAM + output register.
  assign count = mem_count_q
               + CNT_W'(state_q == ST_RD_WAIT)
               + CNT_W'(out_valid_q);
  assign full  = mem_full;
  assign empty = (count == '0);

  // Occupancy of the RAM region never exceeds its depth.
  a_mem_count_bound : assert property (
    @(posedge clk) disable iff (!rst_n) mem_count_q <= CNT_W'(DEPTH)
  );

  // The output register is never occupied while a read is in flight.
  a_no_capture_over_valid : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == ST_RD_WAIT) |-> !out_valid_q
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM beside the DUT, a queue model of
// FIFO contents, directed latency/boundary scenarios and a random run.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_data_out;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_data        (push_data),
    .pop_valid        (pop_valid),
    .pop_ready        (pop_ready),
    .pop_data         (pop_data),
    .count            (count),
    .full             (full),
    .empty            (empty),
    .ram_data_in      (ram_data_in),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  // Behavioural single_port_ram: write at the edge, read data one cycle later.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  initial ram_data_out = '0;
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    else                  ram_data_out <= ram_mem[ram_address];
  end

  int                errors = 0;
  int                checks = 0;
  logic [DATA_W-1:0] q[$];
  int                pushes = 0;
  bit                model_on = 0;
  bit                last_pop;
  logic [DATA_W-1:0] last_pop_data;

  task automatic settle();
    @(negedge clk);
  endtask

  // Checks the queue model against the DUT at the negedge, then advances it.
  task automatic commit();
    bit                pf;
    bit                qf;
    logic [DATA_W-1:0] pd;
    logic [DATA_W-1:0] pdat;
    if (model_on && rst_n) begin
      checks++;
      if (count !== CNT_W'(q.size()))
        $display("FAIL count_model: got %0d expected %0d", count, q.size());
      if (count !== CNT_W'(q.size())) errors++;
      checks++;
      if (empty !== 1'(q.size() == 0)) begin
        errors++;
        $display("FAIL empty_model: got %0b expected %0b", empty, q.size() == 0);
      end
      checks++;
      if (q.size() > DEPTH + 1) begin
        errors++;
        $display("FAIL capacity: held %0d expected at most %0d", q.size(), DEPTH + 1);
      end
      if (pop_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL head_data: pop_valid with model empty, got %0h", pop_data);
        end else if (pop_data !== q[0]) begin
          errors++;
          $display("FAIL head_data: got %0h expected %0h", pop_data, q[0]);
        end
      end
      if (ram_write_enable === 1'b1) begin
        checks++;
        if (ram_address !== ADDR_W'(pushes % DEPTH)) begin
          errors++;
          $display("FAIL write_addr: got %0d expected %0d", ram_address, pushes % DEPTH);
        end
      end
    end
    pf   = push_valid && push_ready;
    qf   = pop_valid && pop_ready;
    pd   = push_data;
    pdat = pop_data;
    last_pop = 0;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      pushes = 0;
    end else begin
      if (qf && q.size() > 0) begin
        last_pop      = 1;
        last_pop_data = pdat;
        void'(q.pop_front());
      end
      if (pf) begin
        q.push_back(pd);
        pushes++;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    commit();
  endtask

  task automatic test_reset();
    model_on = 0;
    rst_n    = 1'b0;
    repeat (2) begin
      push_valid = 1'($urandom);
      pop_ready  = 1'($urandom);
      push_data  = DATA_W'($urandom);
      tick();
    end
    settle();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %0b expected 0", pop_valid); end
    checks++; if (pop_data !== '0) begin errors++; $display("FAIL reset_pop_data: got %0h expected 0", pop_data); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    commit();
    rst_n      = 1'b1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    settle();
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %0b expected 1", push_ready); end
    model_on = 1;
    commit();
  endtask

  task automatic test_single();
    push_valid = 1'b1;
    push_data  = 8'h10;
    pop_ready  = 1'b0;
    settle();
    checks++; if (ram_write_enable !== 1'b1) begin errors++; $display("FAIL single_we_t0: got %0b expected 1", ram_write_enable); end
    checks++; if (ram_address !== 6'd0) begin errors++; $display("FAIL single_addr_t0: got %0d expected 0", ram_address); end
    commit();
    push_valid = 1'b0;
    push_data  = DATA_W'($urandom);
    settle();
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL single_we_t1: got %0b expected 0", ram_write_enable); end
    checks++; if (ram_address !== 6'd0) begin errors++; $display("FAIL single_addr_t1: got %0d expected 0", ram_address); end
    commit();
    settle();
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", pop_valid); end
    commit();
    settle();
    checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t3: got %0b expected 1", pop_valid); end
    checks++; if (pop_data !== 8'h10) begin errors++; $display("FAIL single_data_t3: got %0h expected 10", pop_data); end
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL single_count_t3: got %0d expected 1", count); end
    commit();
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    int acc = 0;
    int popped = 0;
    bit f;
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    for (int c = 0; c < 400 && acc < DEPTH + 1; c++) begin
      push_data = DATA_W'(acc);
      settle();
      f = push_ready;
      commit();
      if (f) acc++;
    end
    checks++; if (acc != DEPTH + 1) begin errors++; $display("FAIL fill_accepted: got %0d expected 65", acc); end
    push_data = 8'h41;
    repeat (3) begin
      settle();
      checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_push_ready: got %0b expected 0", push_ready); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
      checks++; if (count !== 7'd65) begin errors++; $display("FAIL fill_count: got %0d expected 65", count); end
      commit();
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int c = 0; c < 400 && popped < DEPTH + 1; c++) begin
      tick();
      if (last_pop) begin
        checks++;
        if (last_pop_data !== DATA_W'(popped)) begin
          errors++;
          $display("FAIL drain_order: got %0h expected %0h", last_pop_data, popped);
        end
        popped++;
      end
    end
    checks++; if (popped != DEPTH + 1) begin errors++; $display("FAIL drain_count: got %0d expected 65", popped); end
    settle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", empty); end
    commit();
    pop_ready = 1'b0;
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] got[$];
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'h5A;
    settle();
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL coll_first_ready: got %0b expected 1", push_ready); end
    commit();
    push_data = 8'hAF;
    settle();
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL coll_blocked: got %0b expected 0", push_ready); end
    checks++; if (ram_address !== ADDR_W'((pushes - 1) % DEPTH)) begin errors++; $display("FAIL coll_rd_addr: got %0d expected %0d", ram_address, (pushes - 1) % DEPTH); end
    commit();
    settle();
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL coll_retry_ready: got %0b expected 1", push_ready); end
    checks++; if (ram_write_enable !== 1'b1) begin errors++; $display("FAIL coll_retry_we: got %0b expected 1", ram_write_enable); end
    commit();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int c = 0; c < 20 && got.size() < 2; c++) begin
      tick();
      if (last_pop) got.push_back(last_pop_data);
    end
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL coll_pops: got %0d words expected 2", got.size());
    end else if (got[0] !== 8'h5A || got[1] !== 8'hAF) begin
      errors++;
      $display("FAIL coll_order: got %0h,%0h expected 5a,af", got[0], got[1]);
    end
    pop_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'h33;
    tick();
    push_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL midrst_pop_valid: got %0b expected 0", pop_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
    commit();
    push_valid = 1'b1;
    push_data  = 8'h11;
    settle();
    checks++; if (ram_address !== 6'd0 || ram_write_enable !== 1'b1) begin errors++; $display("FAIL midrst_write: got addr %0d we %0b expected addr 0 we 1", ram_address, ram_write_enable); end
    commit();
    push_valid = 1'b0;
    tick();
    tick();
    settle();
    checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h11) begin errors++; $display("FAIL midrst_repush: got valid %0b data %0h expected valid 1 data 11", pop_valid, pop_data); end
    commit();
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got = 0;
    int maxc = 0;
    bit pf;
    for (int c = 0; c < 4000 && got < 200; c++) begin
      push_valid = (sent < 200) && ($urandom_range(3) != 0);
      push_data  = DATA_W'($urandom);
      pop_ready  = ($urandom_range(2) != 0);
      settle();
      pf = push_valid && push_ready;
      if (int'(count) > maxc) maxc = int'(count);
      commit();
      if (pf) sent++;
      if (last_pop) got++;
    end
    checks++; if (sent != 200) begin errors++; $display("FAIL wrap_sent: got %0d expected 200", sent); end
    checks++; if (got != 200) begin errors++; $display("FAIL wrap_popped: got %0d expected 200", got); end
    checks++; if (maxc > DEPTH + 1) begin errors++; $display("FAIL wrap_max_count: got %0d expected at most 65", maxc); end
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    settle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
    commit();
  endtask

  initial begin
    rst_n      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    push_data  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_collision();
    test_reset_mid_read();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
